// File: rtl/bcd_digit_scanner.sv
// Sequential double-dabble binary-to-BCD converter with a time-multiplexed
// four-digit scan output, leading-zero blanking and overflow indication.
module bcd_digit_scanner #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [13:0] i_value,
    input  logic        i_blank_zeros,
    output logic        o_busy,
    output logic [4:0]  o_digit_code,
    output logic [3:0]  o_digit_sel
);
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_step;
    logic [13:0]   r_shift;
    logic [15:0]   r_scratch;
    logic [15:0]   w_adj;
    logic          r_ovf_pend;
    logic          r_blank_pend;
    logic [15:0]   r_disp;
    logic          r_ovf;
    logic          r_blank;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    w_nib;
    logic          w_upper_zero;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_load) w_next_state = S_CONVERT;
            S_CONVERT: if (r_step == 4'd13) w_next_state = S_COMMIT;
            S_COMMIT:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that would reach >= 10 after the shift
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < 4; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_step       <= '0;
            r_shift      <= '0;
            r_scratch    <= '0;
            r_ovf_pend   <= 1'b0;
            r_blank_pend <= 1'b0;
            r_disp       <= '0;
            r_ovf        <= 1'b0;
            r_blank      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        r_shift      <= i_value;
                        r_blank_pend <= i_blank_zeros;
                        r_ovf_pend   <= (i_value > 14'd9999);
                        r_scratch    <= '0;
                        r_step       <= '0;
                    end
                end
                S_CONVERT: begin
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_step               <= r_step + 4'd1;
                end
                S_COMMIT: begin
                    r_disp  <= r_scratch;
                    r_ovf   <= r_ovf_pend;
                    r_blank <= r_blank_pend;
                end
                default: ;
            endcase
        end
    end

    // Scan timing is free-running and never disturbed by conversions
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_comb begin
        w_nib        = r_disp[{r_idx, 2'b00} +: 4];
        w_upper_zero = ((r_disp >> {r_idx, 2'b00}) == 16'd0);
        o_busy       = (r_state != S_IDLE);
        o_digit_code = r_ovf ? 5'h1F : {1'b0, w_nib};
        o_digit_sel  = 4'b0001 << r_idx;
        if (r_blank && !r_ovf && (r_idx != 2'd0) && w_upper_zero) o_digit_sel = 4'b0000;
    end
endmodule
